// File: rtl/inst_queue16_32_pkg.sv
// Shared sizes, word types and the NOP encoding for the fetch/decode instruction queue.
package inst_queue16_32_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_WIDTH = 32;
  localparam int IQ_PTR_W = 4;
  localparam int IQ_CNT_W = 5;

  typedef logic [IQ_WIDTH-1:0] iq_word_t;
  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

  localparam iq_word_t IQ_NOP = 32'h0000_0000;

  localparam iq_cnt_t IQ_FULL_CNT = iq_cnt_t'(IQ_DEPTH);

endpackage

// File: rtl/inst_queue16_32_if.sv
// Push (fetch) and pop (decode) handshake bundle for the instruction queue.
interface inst_queue16_32_if;
  import inst_queue16_32_pkg::*;

  logic     push_valid;
  logic     push_ready;
  iq_word_t push_data;
  logic     pop_valid;
  logic     pop_ready;
  iq_word_t pop_data;
  iq_cnt_t  count;

  // master is the pipeline side driving pushes and taking pops; slave is the queue
  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );

endinterface

// File: rtl/inst_queue16_32_mux.sv
// 16:1 32-bit word read mux; sel picks one of s0..s15 onto out.
module mux16to1_32 (
  input  logic [3:0]  sel,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic [31:0] s3,
  input  logic [31:0] s4,
  input  logic [31:0] s5,
  input  logic [31:0] s6,
  input  logic [31:0] s7,
  input  logic [31:0] s8,
  input  logic [31:0] s9,
  input  logic [31:0] s10,
  input  logic [31:0] s11,
  input  logic [31:0] s12,
  input  logic [31:0] s13,
  input  logic [31:0] s14,
  input  logic [31:0] s15,
  output logic [31:0] out
);

  always_comb begin
    out = s0;
    case (sel)
      4'd0:  out = s0;
      4'd1:  out = s1;
      4'd2:  out = s2;
      4'd3:  out = s3;
      4'd4:  out = s4;
      4'd5:  out = s5;
      4'd6:  out = s6;
      4'd7:  out = s7;
      4'd8:  out = s8;
      4'd9:  out = s9;
      4'd10: out = s10;
      4'd11: out = s11;
      4'd12: out = s12;
      4'd13: out = s13;
      4'd14: out = s14;
      4'd15: out = s15;
      default: out = s0;
    endcase
  end

endmodule

// File: rtl/inst_queue16_32.sv
// 16-entry show-ahead instruction queue between fetch and decode.
// Head word is always visible on pop_data through the 16:1 read mux.
module inst_queue16_32
  import inst_queue16_32_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  inst_queue16_32_if.slave q
);

  iq_word_t entry [IQ_DEPTH];
  iq_ptr_t  head;
  iq_ptr_t  tail;
  iq_cnt_t  cnt;
  logic     push_fire;
  logic     pop_fire;

  // handshakes depend only on registered occupancy, never on the other side's valid/ready
  assign q.push_ready = (cnt != IQ_FULL_CNT);
  assign q.pop_valid  = (cnt != '0);
  assign q.count      = cnt;

  assign push_fire = q.push_valid & q.push_ready;
  assign pop_fire  = q.pop_valid & q.pop_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IQ_DEPTH; i++) entry[i] <= IQ_NOP;
    end else if (!flush && push_fire) begin
      entry[tail] <= q.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_fire) tail <= tail + 1'b1;
      if (pop_fire)  head <= head + 1'b1;
      cnt <= cnt + iq_cnt_t'(push_fire) - iq_cnt_t'(pop_fire);
    end
  end

  mux16to1_32 u_read_mux (
    .sel (head),
    .s0  (entry[0]),
    .s1  (entry[1]),
    .s2  (entry[2]),
    .s3  (entry[3]),
    .s4  (entry[4]),
    .s5  (entry[5]),
    .s6  (entry[6]),
    .s7  (entry[7]),
    .s8  (entry[8]),
    .s9  (entry[9]),
    .s10 (entry[10]),
    .s11 (entry[11]),
    .s12 (entry[12]),
    .s13 (entry[13]),
    .s14 (entry[14]),
    .s15 (entry[15]),
    .out (q.pop_data)
  );

endmodule
